// File: rtl/position_move_sequencer.sv
// Ramps desired_pos toward a commanded target one step per control tick, then waits for the position to settle.
// Commands are accepted in one clk while idle; aborts act on the next edge, and moves are timed by ticks.
module position_move_sequencer #(
  parameter int DIVIDER       = 5000,
  parameter int SETTLE_TICKS  = 200,
  parameter int SETTLE_WINDOW = 4,
  parameter int FOLLOW_LIMIT  = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [31:0] cmd_target,
  input  logic        [15:0] cmd_step,
  input  logic               abort,
  input  logic               clear_fault,
  input  logic signed [31:0] actual_pos,
  output logic signed [31:0] desired_pos,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic        [1:0]  state
);

  localparam int TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(DIVIDER - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
  localparam logic [32:0]   WINDOW      = 33'(SETTLE_WINDOW);
  localparam logic [32:0]   LIMIT       = 33'(FOLLOW_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic signed [31:0] target_q, target_n, desired_n;
  logic [15:0]        step_q, step_n;
  logic [SW-1:0]      settle_q, settle_n;
  logic               done_n;

  logic signed [32:0] rem, follow_err, settle_err;
  logic [32:0]        rem_abs, follow_abs, settle_abs, step_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == '0);

  // All position differences use 33 bits so extreme 32-bit operands cannot wrap.
  assign rem        = {target_q[31], target_q} - {desired_pos[31], desired_pos};
  assign follow_err = {desired_pos[31], desired_pos} - {actual_pos[31], actual_pos};
  assign settle_err = {target_q[31], target_q} - {actual_pos[31], actual_pos};
  assign rem_abs    = rem[32] ? -rem : rem;
  assign follow_abs = follow_err[32] ? -follow_err : follow_err;
  assign settle_abs = settle_err[32] ? -settle_err : settle_err;
  assign step_ext   = {17'b0, step_q};

  always_comb begin
    state_n   = state_q;
    desired_n = desired_pos;
    target_n  = target_q;
    step_n    = step_q;
    settle_n  = settle_q;
    done_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          target_n = cmd_target;
          step_n   = (cmd_step == 16'd0) ? 16'd1 : cmd_step;
          state_n  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          if (follow_abs > LIMIT) begin
            state_n   = ST_FAULT;
            desired_n = actual_pos;
          end else if (rem_abs <= step_ext) begin
            desired_n = target_q;
            settle_n  = '0;
            state_n   = ST_SETTLE;
          end else if (!rem[32]) begin
            desired_n = desired_pos + {16'b0, step_q};
          end else begin
            desired_n = desired_pos - {16'b0, step_q};
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          if (follow_abs > LIMIT) begin
            state_n   = ST_FAULT;
            desired_n = actual_pos;
          end else if (settle_abs <= WINDOW) begin
            settle_n = settle_q + SW'(1);
            if (settle_q == SETTLE_LAST) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end else begin
            settle_n = '0;
          end
        end
      end
      ST_FAULT: begin
        if (clear_fault) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      desired_pos <= '0;
      target_q    <= '0;
      step_q      <= '0;
      settle_q    <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      desired_pos <= desired_n;
      target_q    <= target_n;
      step_q      <= step_n;
      settle_q    <= settle_n;
      done        <= done_n;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign busy      = (state_q == ST_MOVE) || (state_q == ST_SETTLE);
  assign fault     = (state_q == ST_FAULT);
  assign state     = state_q;

endmodule

// File: tb/tb_position_move_sequencer.sv
// Directed scenario bench for position_move_sequencer with a small divider and settle window.
module tb_position_move_sequencer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic signed [31:0] cmd_target = '0;
  logic        [15:0] cmd_step = '0;
  logic               abort = 1'b0;
  logic               clear_fault = 1'b0;
  logic signed [31:0] actual_pos = '0;
  logic signed [31:0] desired_pos;
  logic               busy;
  logic               done;
  logic               fault;
  logic        [1:0]  state;

  int errors = 0;
  int checks = 0;
  int tb_div;

  int basic_exp [4] = '{3, 6, 9, 10};
  int neg_exp   [2] = '{-1, -2};
  int fol_exp   [3] = '{20, 40, 60};
  int rst_act   [6] = '{4, 4, 9, 4, 4, 4};
  int rst_st    [6] = '{2, 2, 2, 2, 2, 0};
  int rst_done  [6] = '{0, 0, 0, 0, 0, 1};

  position_move_sequencer #(
    .DIVIDER(4), .SETTLE_TICKS(3), .SETTLE_WINDOW(2), .FOLLOW_LIMIT(50)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .abort(abort),
    .clear_fault(clear_fault), .actual_pos(actual_pos), .desired_pos(desired_pos),
    .busy(busy), .done(done), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Reference tick schedule: a tick edge is one where this counter was 0 beforehand.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_div <= 0;
    else       tb_div <= (tb_div == 3) ? 0 : tb_div + 1;
  end

  task automatic next_tick();
    @(negedge clk);
    while (tb_div != 0) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; clear_fault = 1'b0; actual_pos = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue_cmd(input logic signed [31:0] t, input logic [15:0] s);
    @(negedge clk);
    cmd_target = t; cmd_step = s; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({state, busy, done, fault, cmd_ready} !== 6'b000001) begin errors++;
      $display("FAIL reset_flags: state=%0d busy=%b done=%b fault=%b ready=%b expected 0 0 0 0 1", state, busy, done, fault, cmd_ready); end
    checks++; if (desired_pos !== 32'sd0) begin errors++;
      $display("FAIL reset_desired: desired_pos=%0d expected 0", desired_pos); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_move();
    do_reset();
    issue_cmd(10, 3);
    checks++; if ({state, busy, cmd_ready} !== 4'b0110) begin errors++;
      $display("FAIL basic_accept: state=%0d busy=%b ready=%b expected 1 1 0", state, busy, cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      next_tick();
      checks++; if (desired_pos !== basic_exp[i]) begin errors++;
        $display("FAIL basic_ramp%0d: desired_pos=%0d expected %0d", i, desired_pos, basic_exp[i]); end
      checks++; if (state !== ((i < 3) ? 2'd1 : 2'd2)) begin errors++;
        $display("FAIL basic_state%0d: state=%0d expected %0d", i, state, (i < 3) ? 1 : 2); end
      actual_pos = basic_exp[i];
    end
    for (int i = 0; i < 3; i++) begin
      next_tick();
      checks++; if ({state, done} !== ((i < 2) ? 3'b100 : 3'b001)) begin errors++;
        $display("FAIL basic_settle%0d: state=%0d done=%b expected %0d %0d", i, state, done, (i < 2) ? 2 : 0, (i < 2) ? 0 : 1); end
    end
    checks++; if ({cmd_ready, desired_pos} !== {1'b1, 32'sd10}) begin errors++;
      $display("FAIL basic_end: ready=%b desired_pos=%0d expected 1 10", cmd_ready, desired_pos); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL basic_done_width: done=%b expected 0 one clk later", done); end
  endtask

  task automatic test_negative_step0();
    do_reset();
    issue_cmd(-2, 16'd0);
    for (int i = 0; i < 2; i++) begin
      next_tick();
      checks++; if (desired_pos !== neg_exp[i]) begin errors++;
        $display("FAIL neg_ramp%0d: desired_pos=%0d expected %0d", i, desired_pos, neg_exp[i]); end
      actual_pos = neg_exp[i];
    end
    checks++; if (state !== 2'd2) begin errors++;
      $display("FAIL neg_settle_entry: state=%0d expected 2", state); end
    for (int i = 0; i < 3; i++) next_tick();
    checks++; if ({state, done} !== 3'b001) begin errors++;
      $display("FAIL neg_done: state=%0d done=%b expected 0 1", state, done); end
  endtask

  task automatic test_follow_error();
    do_reset();
    issue_cmd(1000, 20);
    for (int i = 0; i < 3; i++) begin
      next_tick();
      checks++; if (desired_pos !== fol_exp[i]) begin errors++;
        $display("FAIL follow_ramp%0d: desired_pos=%0d expected %0d", i, desired_pos, fol_exp[i]); end
    end
    next_tick();
    checks++; if ({state, fault, busy} !== 4'b1110) begin errors++;
      $display("FAIL follow_fault: state=%0d fault=%b busy=%b expected 3 1 0", state, fault, busy); end
    checks++; if (desired_pos !== 32'sd0) begin errors++;
      $display("FAIL follow_load: desired_pos=%0d expected 0", desired_pos); end
    actual_pos = 7; abort = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++;
      $display("FAIL fault_ready: cmd_ready=%b expected 0", cmd_ready); end
    next_tick();
    checks++; if ({state, desired_pos} !== {2'd3, 32'sd0}) begin errors++;
      $display("FAIL fault_hold: state=%0d desired_pos=%0d expected 3 0", state, desired_pos); end
    abort = 1'b0;
    @(negedge clk); clear_fault = 1'b1;
    @(posedge clk); #1;
    clear_fault = 1'b0;
    checks++; if ({state, fault, desired_pos} !== {2'd0, 1'b0, 32'sd0}) begin errors++;
      $display("FAIL fault_clear: state=%0d fault=%b desired_pos=%0d expected 0 0 0", state, fault, desired_pos); end
  endtask

  task automatic test_abort();
    logic done_seen;
    do_reset();
    issue_cmd(100, 3);
    clear_fault = 1'b1;
    next_tick();
    clear_fault = 1'b0;
    checks++; if ({state, desired_pos} !== {2'd1, 32'sd3}) begin errors++;
      $display("FAIL abort_clrfault_ignored: state=%0d desired_pos=%0d expected 1 3", state, desired_pos); end
    actual_pos = 3;
    next_tick();
    actual_pos = 6;
    @(negedge clk);
    while (tb_div != 0) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    checks++; if ({state, done, cmd_ready} !== 4'b0000) begin errors++;
      $display("FAIL abort_idle: state=%0d done=%b ready=%b expected 0 0 0", state, done, cmd_ready); end
    checks++; if (desired_pos !== 32'sd6) begin errors++;
      $display("FAIL abort_frozen: desired_pos=%0d expected 6", desired_pos); end
    @(negedge clk);
    cmd_target = 50; cmd_step = 1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL abort_blocks_cmd: state=%0d expected 0", state); end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      done_seen = done_seen | done;
    end
    checks++; if ({done_seen, state, desired_pos} !== {1'b0, 2'd0, 32'sd6}) begin errors++;
      $display("FAIL abort_after: done_seen=%b state=%0d desired_pos=%0d expected 0 0 6", done_seen, state, desired_pos); end
  endtask

  task automatic test_settle_restart();
    do_reset();
    issue_cmd(4, 5);
    next_tick();
    checks++; if ({state, desired_pos} !== {2'd2, 32'sd4}) begin errors++;
      $display("FAIL restart_entry: state=%0d desired_pos=%0d expected 2 4", state, desired_pos); end
    for (int i = 0; i < 6; i++) begin
      actual_pos = rst_act[i];
      next_tick();
      checks++; if ({state, done} !== {rst_st[i][1:0], rst_done[i][0]}) begin errors++;
        $display("FAIL restart_tick%0d: state=%0d done=%b expected %0d %0d", i, state, done, rst_st[i], rst_done[i]); end
      checks++; if (desired_pos !== 32'sd4) begin errors++;
        $display("FAIL restart_hold%0d: desired_pos=%0d expected 4", i, desired_pos); end
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    issue_cmd(100, 3);
    next_tick();
    actual_pos = 3;
    checks++; if (desired_pos !== 32'sd3) begin errors++;
      $display("FAIL rmid_pre: desired_pos=%0d expected 3", desired_pos); end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if ({state, busy, done, fault, cmd_ready} !== 6'b000001) begin errors++;
      $display("FAIL rmid_async_flags: state=%0d busy=%b done=%b fault=%b ready=%b expected 0 0 0 0 1", state, busy, done, fault, cmd_ready); end
    checks++; if (desired_pos !== 32'sd0) begin errors++;
      $display("FAIL rmid_async_desired: desired_pos=%0d expected 0", desired_pos); end
    actual_pos = 0;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    cmd_target = 100; cmd_step = 7; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (state !== 2'd1) begin errors++;
      $display("FAIL rmid_accept: state=%0d expected 1", state); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (desired_pos !== 32'sd0) begin errors++;
      $display("FAIL rmid_no_early_tick: desired_pos=%0d expected 0", desired_pos); end
    @(posedge clk); #1;
    checks++; if (desired_pos !== 32'sd7) begin errors++;
      $display("FAIL rmid_tick_phase: desired_pos=%0d expected 7", desired_pos); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_negative_step0();
    test_follow_error();
    test_abort();
    test_settle_restart();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/position_move_sequencer.md
POSITION_MOVE_SEQUENCER -- requirements
Module: position_move_sequencer

Interface
REQ-001 The block SHALL have these parameters: DIVIDER, default 5000, clocks per control tick (100 MHz to 20 kHz); SETTLE_TICKS, default 200, in-window ticks required to finish; SETTLE_WINDOW, default 4, in-position tolerance in counts; FOLLOW_LIMIT, default 100000, maximum |desired_pos - actual_pos| in counts.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports, as name, direction, width, meaning:
- clk, in, 1, system clock
- reset, in, 1, async active-high reset
- cmd_valid, in, 1, move command offered
- cmd_ready, out, 1, command can be accepted
- cmd_target, in, 32 signed, absolute target position (counts)
- cmd_step, in, 16 unsigned, maximum position increment per tick
- abort, in, 1, stop current move
- clear_fault, in, 1, leave FAULT
- actual_pos, in, 32 signed, measured position
- desired_pos, out, 32 signed, setpoint driven to the PID position loop
- busy, out, 1, state is MOVE or SETTLE
- done, out, 1, one-clk pulse on successful completion
- fault, out, 1, state is FAULT
- state, out, 2, 0=IDLE, 1=MOVE, 2=SETTLE, 3=FAULT

Function
REQ-004 A tick counter SHALL count 0..DIVIDER-1 and wrap; tick SHALL be high when the counter is 0, so the first tick falls in the first clk after reset deasserts.
REQ-005 cmd_ready SHALL equal (state==IDLE) && !abort.
REQ-006 On cmd_valid && cmd_ready, the block SHALL latch cmd_target and cmd_step, with step 0 replaced by 1, and enter MOVE on the same edge.
REQ-007 In MOVE, on each tick, the block SHALL compute rem = target - desired_pos at 33-bit signed width.
REQ-008 In MOVE, if |rem| <= step, desired_pos SHALL be set to target and the state SHALL go to SETTLE.
REQ-009 In MOVE, if |rem| > step, desired_pos SHALL change by +step when rem > 0 and by -step otherwise.
REQ-010 SETTLE SHALL hold desired_pos at target and keep a settle counter: on each tick it increments when |target - actual_pos| <= SETTLE_WINDOW and clears to 0 otherwise.
REQ-011 When the settle counter reaches SETTLE_TICKS, the block SHALL go to IDLE and pulse done for exactly 1 clk.
REQ-012 In MOVE and SETTLE, on each tick, if |desired_pos - actual_pos| > FOLLOW_LIMIT (33-bit compare), the block SHALL enter FAULT; this check has priority over REQ-008 to REQ-011 on the same tick.
REQ-013 On entry to FAULT, desired_pos SHALL be loaded with actual_pos once and then held.
REQ-014 FAULT SHALL be left only via clear_fault, which returns the state to IDLE on the next edge; clear_fault in any other state SHALL be ignored.
REQ-015 abort in MOVE or SETTLE SHALL force IDLE on the next edge with desired_pos frozen and no done pulse; abort SHALL have priority over tick actions.
REQ-016 abort in IDLE or FAULT SHALL have no effect other than REQ-005.
REQ-017 desired_pos SHALL change only on ticks in MOVE, on FAULT entry, and at reset; in IDLE it holds its last value.
REQ-018 The settle counter SHALL clear on every entry to SETTLE.
REQ-019 The FOLLOW_LIMIT check SHALL be evaluated against desired_pos before that tick's update.

Reset
REQ-020 While reset is high, the block SHALL hold state=IDLE, desired_pos=0, done=0, busy=0, fault=0, the tick counter at 0, the settle counter at 0, and latched target and step at 0.
REQ-021 Reset asserted mid-move SHALL abandon the move immediately with no done pulse.

Verification (DIVIDER=4, SETTLE_TICKS=3, SETTLE_WINDOW=2, FOLLOW_LIMIT=50)
REQ-022 Bench scenario, basic move: actual_pos tracks desired_pos; command target=10, step=3 -> desired_pos 3,6,9,10 on successive ticks, then SETTLE, then a single done pulse after 3 ticks, and cmd_ready returns to 1.
REQ-023 Bench scenario, negative move with step 0: target=-2, step=0 -> desired_pos -1, -2, then SETTLE, then done.
REQ-024 Bench scenario, following error: actual_pos fixed at 0, target=1000, step=20 -> FAULT on the tick desired_pos=60 is observed; desired_pos becomes 0; clear_fault returns the state to IDLE.
REQ-025 Bench scenario, abort: assert abort while desired_pos=6 in MOVE -> IDLE next clk, desired_pos stays 6, no done pulse; cmd_valid with abort high in IDLE is not accepted.
REQ-026 Bench scenario, settle restart: actual_pos leaves the window (|err|=5) after 2 in-window ticks -> the settle counter clears and done occurs only after 3 further consecutive in-window ticks.
REQ-027 Bench scenario, reset mid-move: assert reset in MOVE -> all outputs return to REQ-020 values asynchronously, and the first tick occurs in the first clk after reset release.
